signed_adder_bcd_scan: RTL and testbench
========================================

Name: signed_adder_bcd_scan

Overview:
- Parametrised signed adder feeding a multiplexed N-digit 7-segment display.
- On a start handshake it latches two WIDTH-bit two's-complement operands and forms a WIDTH+1-bit sum.
- It converts the sum's magnitude to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- A free-running refresh counter time-multiplexes DIGITS digit drivers, with sign on DP, optional leading-zero blanking and overflow indication. It sits between the board switches/controller and the display pins.

Parameters:
- WIDTH, 8, operand width in bits (two's complement), 2..16.
- DIGITS, 3, number of display digits, 1..6.
- REFRESH_DIV, 50000, clock cycles each digit stays selected, >=1.
- BLANK_LZ, 1, 1 = blank leading zeros above digit 0; 0 = show all digits.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- a  input  WIDTH  operand 1, signed
- b  input  WIDTH  operand 2, signed
- start  input  1  request; sampled only in IDLE
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the display registers update
- sum  output  WIDTH+1  signed sum of the last completed operation
- neg  output  1  sign of the displayed result
- ovf  output  1  magnitude >= 10^DIGITS for the displayed result
- an  output  DIGITS  one-hot digit select, active-high, bit 0 = rightmost
- seg  output  7  segments {A,B,C,D,E,F,G}, active-high
- dp  output  1  decimal point, active-high

Behaviour:
- Reset (asynchronous, any state):
  - Outputs: busy=0, done=0, sum=0, neg=0, ovf=0, scan index=0, refresh count=0, an=1 (one-hot index 0).
  - State and display: FSM goes to IDLE; all stored digits are 0, so seg=7'b1111110 and dp=0.
  - Reset mid-conversion discards the operation. The display returns to 0, not to the prior result.
- FSM has three states: IDLE, CONV, UPD.
- IDLE:
  - If start=1 at a rising edge, latch s = sext(a)+sext(b) (WIDTH+1 bits, never overflows).
  - Latch mag = |s| as a WIDTH+1-bit unsigned value; max 2^WIDTH fits.
  - Clear the BCD scratch register (4*DIGITS bits), load the shift counter with WIDTH+1, go to CONV, busy=1.
- CONV:
  - Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1 and decrement the counter.
  - After WIDTH+1 cycles, go to UPD.
  - A carry out of the top nibble sets an internal overflow bit (sticky for this operation).
  - Magnitude >= 10^DIGITS also sets it.
- UPD (1 cycle):
  - Copy the BCD digits, neg=s[WIDTH], sum=s and ovf into the display registers.
  - done=1 for exactly this cycle, busy=0 from the next cycle, return to IDLE.
- Latency: start sampled at edge 0 → done high in cycle WIDTH+2 → new digits visible from cycle WIDTH+3.
- start while busy is ignored, with no queuing. start held high in IDLE restarts immediately after UPD, with one IDLE cycle in between.
- A zero sum shows neg=0. -0 is never displayed.
- Scan:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM, including during CONV.
  - On wrap, the scan index increments modulo DIGITS. an = 1<<index.
- seg for the selected digit:
  - ovf=1 → dash 7'b0000001 on every digit.
  - Otherwise, BLANK_LZ=1 and index above the highest nonzero digit and index≠0 → 7'b0000000.
  - Otherwise, the decoded digit. Decoder: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, 10–15 → 0000000.
- dp = neg and index==0 (sign lamp on rightmost digit); dp=0 when ovf=1.
- an, seg and dp are registered together so they change in the same cycle; no glitch between digits.

Decomposition:
- Shared package (seg7_pkg) holds:
  - FSM state encoding (IDLE, CONV, UPD).
  - Segment constants SEG_DASH and SEG_BLANK.
  - The 16-entry digit-to-segment table.
- Sub-module seg7_decode: combinational 4-bit digit → 7-bit seg, using the package table. Instantiated once on the muxed digit.
- The double-dabble step stays inline.

Test Plan (WIDTH=8, DIGITS=3, REFRESH_DIV=4 unless stated):
- Reset asserted mid-scan → an=3'b001, seg=1111110, dp=0, busy=0 immediately, without waiting for a clock edge.
- a=100, b=27, start pulse → busy cycles 1–9, done at cycle 10, sum=127, neg=0. Scan shows 7, 2, 1 on an=001, 010, 100, each for 4 cycles.
- a=-128, b=-128 → sum=-256 (9'h100), neg=1, digits 6, 5, 2, dp=1 only while an=001.
- BLANK_LZ=1, a=-5, b=3 → digit0 = 2 (1101101) with dp=1; digits 1 and 2 seg=0000000. Same with BLANK_LZ=0 → digits 1 and 2 show 1111110.
- DIGITS=2, a=50, b=60 → ovf=1, both digits 0000001, dp=0. Then a=4, b=5 → ovf=0, shows 09 with blanking off.
- start pulsed again during CONV → ignored: single done and first result kept. Reset at cycle 5 of CONV → no done, display 0, a new start then completes normally.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_pkg : FSM encoding, segment constants and digit table for the  |
// |            signed adder / BCD display block.  Rev 1.0               |
// +--------------------------------------------------------------------+
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_UPD  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment order {A,B,C,D,E,F,G}; codes 10..15 are dark.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
    7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seg7_decode : 4-bit digit to active-high 7-segment pattern.         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule
`default_nettype wire

// File: rtl/signed_adder_bcd_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | signed_adder_bcd_scan : signed add, double-dabble BCD conversion    |
// |                         and multiplexed 7-segment scan.  Rev 1.0    |
// +--------------------------------------------------------------------+
module signed_adder_bcd_scan
  import seg7_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH:0]    sum,
  output logic              neg,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int          c_sum_w = WIDTH + 1;
  localparam int          c_bcd_w = 4 * DIGITS;
  localparam int          c_cnt_w = $clog2(WIDTH + 2);
  localparam int          c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          c_ref_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [31:0] c_limit = 32'(pow10(DIGITS));

  state_t               r_state;
  logic [c_sum_w-1:0]   r_s;
  logic [c_sum_w-1:0]   r_mag;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_ovf_acc;
  logic [c_bcd_w-1:0]   r_disp;
  logic [c_ref_w-1:0]   r_ref;
  logic [c_idx_w-1:0]   r_idx;

  logic [c_sum_w-1:0]   w_sum;
  logic [c_sum_w-1:0]   w_mag;
  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_bcd_nx;
  logic [c_sum_w-1:0]   w_mag_nx;
  logic                 w_carry;
  logic [c_idx_w-1:0]   w_hi;
  logic [3:0]           w_digit;
  logic [6:0]           w_dec;
  logic [6:0]           w_seg;
  logic                 w_dp;
  logic [DIGITS-1:0]    w_an;

  // Sign-extended add cannot overflow; -2^WIDTH negates to itself as unsigned.
  assign w_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign w_mag = w_sum[WIDTH] ? -w_sum : w_sum;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    {w_carry, w_bcd_nx, w_mag_nx} = {w_adj, r_mag, 1'b0};
  end

  // The final dabble step loads the display directly, so done and the new
  // result appear together in the UPD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_s       <= '0;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      r_disp    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_s       <= w_sum;
            r_mag     <= w_mag;
            r_bcd     <= '0;
            r_cnt     <= c_cnt_w'(c_sum_w);
            r_ovf_acc <= (32'(w_mag) >= c_limit);
            busy      <= 1'b1;
            r_state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd <= w_bcd_nx;
          r_mag <= w_mag_nx;
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            r_disp  <= w_bcd_nx;
            sum     <= r_s;
            neg     <= r_s[WIDTH];
            ovf     <= r_ovf_acc | w_carry;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_UPD;
          end else begin
            r_ovf_acc <= r_ovf_acc | w_carry;
          end
        end
        ST_UPD:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_hi    = '0;
    w_digit = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (r_disp[4*i +: 4] != 4'd0) w_hi = c_idx_w'(i);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) w_digit = r_disp[4*i +: 4];
    end
  end

  seg7_decode u_dec (
    .digit (w_digit),
    .seg   (w_dec)
  );

  always_comb begin
    w_an  = DIGITS'(1) << r_idx;
    w_seg = w_dec;
    if (ovf) begin
      w_seg = SEG_DASH;
    end else if ((BLANK_LZ != 0) && (r_idx > w_hi) && (r_idx != '0)) begin
      w_seg = SEG_BLANK;
    end
    w_dp = neg & (r_idx == '0) & ~ovf;
  end

  // an/seg/dp share one register stage so digit switches are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref <= '0;
      r_idx <= '0;
      an    <= DIGITS'(1);
      seg   <= SEG_TABLE[0];
      dp    <= 1'b0;
    end else begin
      if (r_ref == c_ref_w'(REFRESH_DIV - 1)) begin
        r_ref <= '0;
        r_idx <= (r_idx == c_idx_w'(DIGITS - 1)) ? '0 : r_idx + c_idx_w'(1);
      end else begin
        r_ref <= r_ref + c_ref_w'(1);
      end
      an  <= w_an;
      seg <= w_seg;
      dp  <= w_dp;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_adder_bcd_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_signed_adder_bcd_scan : vector table + scoreboard bench for      |
// |                            signed_adder_bcd_scan.  Rev 1.0          |
// +--------------------------------------------------------------------+
module tb_signed_adder_bcd_scan;

  localparam int W  = 8;
  localparam int RD = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         start = 1'b0;

  logic busy3, done3, neg3, ovf3, dp3;
  logic [W:0] sum3;  logic [2:0] an3;  logic [6:0] seg3;
  logic busyn, donen, negn, ovfn, dpn;
  logic [W:0] sumn;  logic [2:0] ann;  logic [6:0] segn;
  logic busy2, done2, neg2, ovf2, dp2;
  logic [W:0] sum2;  logic [1:0] an2;  logic [6:0] seg2;

  signed_adder_bcd_scan #(.WIDTH(W), .DIGITS(3), .REFRESH_DIV(RD), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .busy(busy3), .done(done3),
    .sum(sum3), .neg(neg3), .ovf(ovf3), .an(an3), .seg(seg3), .dp(dp3));
  signed_adder_bcd_scan #(.WIDTH(W), .DIGITS(3), .REFRESH_DIV(RD), .BLANK_LZ(0)) u_dut_nb (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .busy(busyn), .done(donen),
    .sum(sumn), .neg(negn), .ovf(ovfn), .an(ann), .seg(segn), .dp(dpn));
  signed_adder_bcd_scan #(.WIDTH(W), .DIGITS(2), .REFRESH_DIV(RD), .BLANK_LZ(0)) u_dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .start(start), .busy(busy2), .done(done2),
    .sum(sum2), .neg(neg2), .ovf(ovf2), .an(an2), .seg(seg2), .dp(dp2));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cur_mag = 0;
  bit cur_neg = 1'b0;

  typedef struct { int sum; bit neg; bit ovf3; bit ovf2; } exp_t;
  typedef struct { int a; int b; int sum; bit neg; bit ovf2; } vec_t;
  exp_t q[$];
  exp_t m_e;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no done want done", name);
  endtask

  function automatic logic [6:0] seg_lut(input int d);
    case (d)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011;  default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [7:0] exp_disp(input int mag, input bit ng, input int digits,
                                          input bit blank, input int idx);
    int lim = 1;
    int p   = 1;
    int hi  = 0;
    bit ov;
    logic [6:0] s;
    for (int i = 0; i < digits; i++) begin
      if (((mag / lim) % 10) != 0) hi = i;
      if (i == idx) p = lim;
      lim = lim * 10;
    end
    ov = (mag >= lim);
    if (ov) s = 7'b0000001;
    else if (blank && idx > hi && idx != 0) s = 7'b0000000;
    else s = seg_lut((mag / p) % 10);
    return {ng && idx == 0 && !ov, s};
  endfunction

  function automatic int onehot_idx(input logic [5:0] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < 6; i++) if (v[i] === 1'b1) begin c++; r = i; end
    return (c == 1) ? r : -1;
  endfunction

  task automatic check_disp(input string name, input logic [5:0] anv, input logic [6:0] sv,
                            input logic dv, input int digits, input bit blank);
    int idx;
    idx = onehot_idx(anv);
    check({name, " an onehot"}, 32'(idx >= 0 && idx < digits), 32'd1);
    if (idx >= 0 && idx < digits)
      check({name, " dp/seg"}, {24'd0, dv, sv}, {24'd0, exp_disp(cur_mag, cur_neg, digits, blank, idx)});
  endtask

  task automatic scan_check(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_disp("d3", {3'b0, an3}, seg3, dp3, 3, 1'b1);
      check_disp("d3nb", {3'b0, ann}, segn, dpn, 3, 1'b0);
      check_disp("d2", {4'b0, an2}, seg2, dp2, 2, 1'b0);
    end
  endtask

  task automatic push_exp(input int esum, input bit eneg, input bit eovf2);
    exp_t e;
    e.sum  = esum;
    e.neg  = eneg;
    e.ovf3 = ((esum < 0) ? -esum : esum) >= 1000;
    e.ovf2 = eovf2;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy3 && n < 40) begin @(negedge clk); n++; end
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_timeout(name);
  endtask

  task automatic count_dones(input string name, input int ncyc);
    int seen = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done3) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  task automatic run_op(input int va, input int vb, input int esum, input bit eneg,
                        input bit eovf2, input string name);
    bit ok;
    wait_idle();
    @(negedge clk);
    a = W'(va); b = W'(vb); start = 1'b1;
    push_exp(esum, eneg, eovf2);
    @(negedge clk);
    start = 1'b0;
    wait_done(name, ok);
    if (ok) begin
      cur_mag = (esum < 0) ? -esum : esum;
      cur_neg = eneg;
      @(negedge clk);
      scan_check(14);
    end
  endtask

  task automatic check_dwell();
    logic [2:0] prev;
    int n = 0;
    @(negedge clk);
    prev = an3;
    while (an3 == prev && n < 10) begin @(negedge clk); n++; end
    prev = an3;
    n = 1;
    @(negedge clk);
    while (an3 == prev && n < 10) begin n++; @(negedge clk); end
    check("digit dwell", 32'(n), 32'(RD));
  endtask

  // Scoreboard: every done must retire exactly one queued expectation.
  always @(negedge clk) begin
    if (!rst && (done3 || donen || done2)) begin
      check("done align", {29'd0, done3, donen, done2}, 32'd7);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_without_start: got done=1 want done=0");
      end else begin
        m_e = q.pop_front();
        check("sum d3", 32'(int'($signed(sum3))), 32'(m_e.sum));
        check("neg d3", 32'(neg3), 32'(m_e.neg));
        check("ovf d3", 32'(ovf3), 32'(m_e.ovf3));
        check("sum d3nb", 32'(int'($signed(sumn))), 32'(m_e.sum));
        check("sum d2", 32'(int'($signed(sum2))), 32'(m_e.sum));
        check("neg d2", 32'(neg2), 32'(m_e.neg));
        check("ovf d2", 32'(ovf2), 32'(m_e.ovf2));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n;
    vecs[0]  = '{100,   27,  127, 1'b0, 1'b1};
    vecs[1]  = '{-128, -128, -256, 1'b1, 1'b1};
    vecs[2]  = '{-5,     3,   -2, 1'b1, 1'b0};
    vecs[3]  = '{50,    60,  110, 1'b0, 1'b1};
    vecs[4]  = '{4,      5,    9, 1'b0, 1'b0};
    vecs[5]  = '{0,      0,    0, 1'b0, 1'b0};
    vecs[6]  = '{127,  127,  254, 1'b0, 1'b1};
    vecs[7]  = '{-1,     1,    0, 1'b0, 1'b0};
    vecs[8]  = '{99,  -100,   -1, 1'b1, 1'b0};
    vecs[9]  = '{-64,  -36, -100, 1'b1, 1'b1};
    vecs[10] = '{45,    54,   99, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy3), 32'd0);
    check("rst done", 32'(done3), 32'd0);
    check("rst sum", 32'(sum3), 32'd0);
    check("rst neg/ovf", {30'd0, neg3, ovf3}, 32'd0);
    check("rst an", 32'(an3), 32'd1);
    check("rst seg", 32'(seg3), 32'h7e);
    check("rst dp", 32'(dp3), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Exact latency of one operation
    a = W'(100); b = W'(27); start = 1'b1;
    push_exp(127, 1'b0, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      check("lat busy", 32'(busy3), 32'(k <= 9));
      check("lat done", 32'(done3), 32'(k == 10));
    end
    cur_mag = 127;
    cur_neg = 1'b0;
    scan_check(14);
    check_dwell();

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].neg, vecs[i].ovf2, "vector");

    // start held high: restart after a single IDLE cycle
    wait_idle();
    @(negedge clk);
    a = W'(3); b = W'(4); start = 1'b1;
    push_exp(7, 1'b0, 1'b0);
    push_exp(7, 1'b0, 1'b0);
    @(negedge clk);
    wait_done("held first", ok);
    @(negedge clk);
    check("held idle gap", 32'(busy3), 32'd0);
    @(negedge clk);
    check("held restart", 32'(busy3), 32'd1);
    start = 1'b0;
    wait_done("held second", ok);
    cur_mag = 7;
    cur_neg = 1'b0;
    @(negedge clk);
    scan_check(14);

    // start during CONV is ignored
    wait_idle();
    @(negedge clk);
    a = W'(-20); b = W'(-3); start = 1'b1;
    push_exp(-23, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = W'(50); b = W'(60); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore start", ok);
    cur_mag = 23;
    cur_neg = 1'b1;
    count_dones("second done", 15);
    scan_check(14);

    // Asynchronous reset mid-scan, checked before any clock edge
    n = 0;
    while (an3 != 3'b100 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst an", 32'(an3), 32'd1);
    check("arst seg", 32'(seg3), 32'h7e);
    check("arst dp", 32'(dp3), 32'd0);
    check("arst busy", 32'(busy3), 32'd0);
    check("arst sum", 32'(sum3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cur_mag = 0;
    cur_neg = 1'b0;
    scan_check(14);

    // Reset mid-conversion discards the operation
    run_op(-100, -27, -127, 1'b1, 1'b1, "pre reset");
    wait_idle();
    @(negedge clk);
    a = W'(88); b = W'(11); start = 1'b1;
    push_exp(99, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("conv rst busy", 32'(busy3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    cur_mag = 0;
    cur_neg = 1'b0;
    count_dones("no done after rst", 15);
    scan_check(14);
    run_op(88, 11, 99, 1'b0, 1'b0, "after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
